// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the UART receive-frame datapath.
// Holds the frame FSM state encoding and frame-length arithmetic.
package rx_frame_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2
   } rx_frame_state_t;

   function automatic int frame_bits(
      input int data_bits,
      input int parity_en,
      input int stop_bits
   );
      return data_bits + parity_en + stop_bits;
   endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// Flexible serial-to-parallel shift register.
// SHIFT_MSB=1 shifts toward the MSB, SHIFT_MSB=0 shifts toward the LSB.
module flex_stp_sr #(
   parameter int NUM_BITS  = 4,
   parameter int SHIFT_MSB = 1
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                shift_enable,
   input  logic                serial_in,
   output logic [NUM_BITS-1:0] parallel_out
);

   logic [NUM_BITS-1:0] next_out;

   // Select the shifted value; serial_in enters the end opposite the shift.
   always_comb begin
      next_out = parallel_out;
      if (shift_enable) begin
         if (SHIFT_MSB != 0)
            next_out = (parallel_out << 1) | NUM_BITS'(serial_in);
         else
            next_out = (parallel_out >> 1)
                     | (NUM_BITS'(serial_in) << (NUM_BITS - 1));
      end
   end

   // Shift register state.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst)
         parallel_out <= '0;
      else
         parallel_out <= next_out;
   end

endmodule

// File: rtl/flex_rx_frame_sr.sv
// UART receive-frame shift register: counts frame bits, then latches
// the data word with parity and stop-bit checks in a single LOAD cycle.
module flex_rx_frame_sr
   import rx_frame_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int LSB_FIRST  = 1
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 clear,
   input  logic                 shift_strobe,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] packet_data,
   output logic                 parity_error,
   output logic                 framing_error,
   output logic                 frame_done,
   output logic                 busy
);

   localparam int FB = frame_bits(DATA_BITS, PARITY_EN, STOP_BITS);
   localparam int CW = $clog2(FB + 1);
   localparam logic [CW-1:0] LAST = CW'(FB - 1);
   // Parity sits just above the data; index is unused without parity.
   localparam int PI = (PARITY_EN != 0) ? DATA_BITS : 0;

   rx_frame_state_t     state;
   logic [CW-1:0]       count;
   logic [FB-1:0]       sr;
   logic                shift_en;
   logic [DATA_BITS-1:0] data_field;
   logic [DATA_BITS-1:0] word;
   logic                par_err;
   logic                frm_err;

   assign shift_en = (state == SHIFT) && shift_strobe && !clear;

   flex_stp_sr #(
      .NUM_BITS  (FB),
      .SHIFT_MSB (0)
   ) u_sr (
      .clk          (clk),
      .n_rst        (n_rst),
      .shift_enable (shift_en),
      .serial_in    (serial_in),
      .parallel_out (sr)
   );

   // Extract the data word in the requested bit order and check the frame.
   always_comb begin
      word       = '0;
      data_field = sr[DATA_BITS-1:0];
      for (int i = 0; i < DATA_BITS; i++) begin
         if (LSB_FIRST != 0)
            word[i] = data_field[i];
         else
            word[i] = data_field[DATA_BITS-1-i];
      end
      par_err = (PARITY_EN != 0)
             && ((^data_field ^ sr[PI]) != (PARITY_ODD != 0));
      frm_err = ~&sr[FB-1 -: STOP_BITS];
   end

   // Frame FSM with bit counter and registered outputs.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state         <= IDLE;
         count         <= '0;
         packet_data   <= '0;
         parity_error  <= 1'b0;
         framing_error <= 1'b0;
         frame_done    <= 1'b0;
         busy          <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (clear) begin
                  state <= SHIFT;
                  count <= '0;
                  busy  <= 1'b1;
               end
            end
            SHIFT: begin
               if (clear) begin
                  count <= '0;
               end else if (shift_strobe) begin
                  count <= count + 1'b1;
                  if (count == LAST)
                     state <= LOAD;
               end
            end
            LOAD: begin
               packet_data   <= word;
               parity_error  <= par_err;
               framing_error <= frm_err;
               frame_done    <= 1'b1;
               count         <= '0;
               if (clear) begin
                  state <= SHIFT;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
